// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] INIT_R0 = 4'h2;
    localparam logic [DATA_W-1:0] INIT_R1 = 4'h1;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_t;

    localparam int REQ_WB = 0;
    localparam int REQ_LD = 1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_gnt_q;
    logic last_gnt_d;

    // One-hot grant from the current requests and the last winner
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_gnt_q == 1'(REQ_LD)) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Remember the winner only when a transfer actually happened
    always_comb begin
        if (upd_i) begin
            last_gnt_d = gnt_o[REQ_LD];
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Last-winner register; resetting to LD hands the first tie to WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'(REQ_LD);
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the register file: round-robin between writeback and load.
// Define REGARB_INIT_EN to compile in the post-reset boot-value walk.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int                DATA_W  = regfile_pkg::DATA_W,
    parameter int                ADDR_W  = regfile_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] INIT_R0 = regfile_pkg::INIT_R0,
    parameter logic [DATA_W-1:0] INIT_R1 = regfile_pkg::INIT_R1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              arb_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign req_s    = {ld_valid, wb_valid};
    assign wb_ready = arb_s & gnt_s[REQ_WB];
    assign ld_ready = arb_s & gnt_s[REQ_LD];
    assign xfer_s   = (wb_valid & wb_ready) | (ld_valid & ld_ready);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_s),
        .upd_i (xfer_s),
        .gnt_o (gnt_s)
    );

    // Address/data of whichever requester holds the grant
    always_comb begin
        if (gnt_s[REQ_LD]) begin
            win_addr_s = ld_addr;
            win_data_s = ld_data;
        end else begin
            win_addr_s = wb_addr;
            win_data_s = wb_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef REGARB_INIT_EN
    localparam int NUM_REGS = 2 ** ADDR_W;

    arb_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] boot_s;
    logic              init_done_q;

    assign arb_s     = (state_q == ARB);
    assign init_done = init_done_q;

    // Boot value for the register currently being walked
    always_comb begin
        case (cnt_q)
            ADDR_W'(0): boot_s = INIT_R0;
            ADDR_W'(1): boot_s = INIT_R1;
            default:    boot_s = {DATA_W{1'b0}};
        endcase
    end

    // Init walk then arbitration; drives the registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= {ADDR_W{1'b0}};
            init_done_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= {ADDR_W{1'b0}};
            rf_wdata_q  <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                INIT: begin
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= cnt_q;
                    rf_wdata_q <= boot_s;
                    cnt_q      <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_q     <= ARB;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q     <= INIT;
                        init_done_q <= 1'b0;
                    end
                end
                ARB: begin
                    rf_we_q <= xfer_s;
                    if (xfer_s) begin
                        rf_waddr_q <= win_addr_s;
                        rf_wdata_q <= win_data_s;
                    end else begin
                        rf_waddr_q <= rf_waddr_q;
                        rf_wdata_q <= rf_wdata_q;
                    end
                end
                default: begin
                    state_q     <= INIT;
                    cnt_q       <= {ADDR_W{1'b0}};
                    init_done_q <= 1'b0;
                    rf_we_q     <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_boot_s;

    // Boot values only matter to the init walk
    assign unused_boot_s = ^{INIT_R0, INIT_R1};
    assign arb_s         = 1'b1;
    assign init_done     = 1'b1;

    // Registered write port: strobe on transfer, otherwise hold address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_W{1'b0}};
            rf_wdata_q <= {DATA_W{1'b0}};
        end else begin
            rf_we_q <= xfer_s;
            if (xfer_s) begin
                rf_waddr_q <= win_addr_s;
                rf_wdata_q <= win_data_s;
            end else begin
                rf_waddr_q <= rf_waddr_q;
                rf_wdata_q <= rf_wdata_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter; covers both REGARB_INIT_EN builds.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_valid = 1'b0;
    logic [1:0] wb_addr = 2'd0;
    logic [3:0] wb_data = 4'h0;
    logic       wb_ready;
    logic       ld_valid = 1'b0;
    logic [1:0] ld_addr = 2'd0;
    logic [3:0] ld_data = 4'h0;
    logic       ld_ready;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic       init_done;

    regfile_wr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [1:0] wa;
        logic [3:0] wd;
        logic       lv;
        logic [1:0] la;
        logic [3:0] ldat;
        logic       ewr;
        logic       elr;
    } vec_t;

    typedef struct {
        logic       we;
        logic [1:0] a;
        logic [3:0] d;
    } wr_t;

    wr_t        sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] mdl_a = 2'd0;
    logic [3:0] mdl_d = 4'h0;
    logic [3:0] boot_tab [4] = '{4'h2, 4'h1, 4'h0, 4'h0};
    vec_t       tab  [14];
    vec_t       post [4];

`ifdef REGARB_INIT_EN
    localparam logic EXP_DONE_RST = 1'b0;
`else
    localparam logic EXP_DONE_RST = 1'b1;
`endif

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm);
        wr_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            chk({nm, " rf_we"}, 8'(rf_we), 8'(e.we));
            chk({nm, " rf_waddr"}, 8'(rf_waddr), 8'(e.a));
            chk({nm, " rf_wdata"}, 8'(rf_wdata), 8'(e.d));
        end
    endtask

    // Called just after a rising edge: drive, check readies, push, then check the write
    task automatic run_cycle(input vec_t v, input string nm);
        wr_t e;
        wb_valid = v.wv; wb_addr = v.wa; wb_data = v.wd;
        ld_valid = v.lv; ld_addr = v.la; ld_data = v.ldat;
        #1;
        chk({nm, " wb_ready"}, 8'(wb_ready), 8'(v.ewr));
        chk({nm, " ld_ready"}, 8'(ld_ready), 8'(v.elr));
        chk({nm, " init_done"}, 8'(init_done), 8'h01);
        e.we = (v.wv & v.ewr) | (v.lv & v.elr);
        if (v.wv & v.ewr) begin
            mdl_a = v.wa; mdl_d = v.wd;
        end else if (v.lv & v.elr) begin
            mdl_a = v.la; mdl_d = v.ldat;
        end
        e.a = mdl_a; e.d = mdl_d;
        sb_q.push_back(e);
        @(posedge clk); #1;
        check_out(nm);
    endtask

    // Boot walk after reset release; wb may be held pending throughout
    task automatic init_walk(input logic hold_wb, input string nm);
`ifdef REGARB_INIT_EN
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            wb_valid = hold_wb; wb_addr = 2'd2; wb_data = 4'hA;
            ld_valid = 1'b0;
            #1;
            chk($sformatf("%s[%0d] wb_ready", nm, i), 8'(wb_ready), 8'h00);
            chk($sformatf("%s[%0d] ld_ready", nm, i), 8'(ld_ready), 8'h00);
            chk($sformatf("%s[%0d] init_done", nm, i), 8'(init_done), 8'h00);
            e.we = 1'b1; e.a = 2'(i); e.d = boot_tab[i];
            mdl_a = e.a; mdl_d = e.d;
            sb_q.push_back(e);
            @(posedge clk); #1;
            check_out($sformatf("%s[%0d]", nm, i));
        end
`else
        chk({nm, " init_done"}, 8'(init_done), 8'h01);
        wb_valid = hold_wb;
`endif
    endtask

    initial begin
        tab = '{
            '{1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0},
            '{1'b0, 2'd0, 4'h0, 1'b1, 2'd3, 4'hC, 1'b0, 1'b1},
            '{1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 4'h7, 1'b0, 1'b1},
            '{1'b1, 2'd1, 4'h5, 1'b1, 2'd3, 4'hC, 1'b1, 1'b0},
            '{1'b1, 2'd1, 4'h5, 1'b1, 2'd3, 4'hC, 1'b0, 1'b1},
            '{1'b1, 2'd1, 4'h5, 1'b1, 2'd3, 4'hC, 1'b1, 1'b0},
            '{1'b1, 2'd1, 4'h5, 1'b1, 2'd3, 4'hC, 1'b0, 1'b1},
            '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0},
            '{1'b1, 2'd0, 4'hF, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0},
            '{1'b1, 2'd0, 4'h3, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0},
            '{1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 4'h9, 1'b0, 1'b1},
            '{1'b1, 2'd3, 4'h6, 1'b1, 2'd1, 4'hE, 1'b1, 1'b0},
            '{1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 4'hE, 1'b0, 1'b1}
        };
        post = '{
            '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0},
            '{1'b1, 2'd0, 4'h1, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0},
            '{1'b1, 2'd2, 4'h3, 1'b1, 2'd1, 4'h2, 1'b0, 1'b1},
            '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0}
        };

        #2;
        chk("rst rf_we", 8'(rf_we), 8'h00);
        chk("rst rf_waddr", 8'(rf_waddr), 8'h00);
        chk("rst rf_wdata", 8'(rf_wdata), 8'h00);
        chk("rst wb_ready", 8'(wb_ready), 8'h00);
        chk("rst ld_ready", 8'(ld_ready), 8'h00);
        chk("rst init_done", 8'(init_done), 8'(EXP_DONE_RST));
        @(posedge clk); #1;
        rst_n = 1'b1;

        init_walk(1'b1, "init1");
        for (int i = 0; i < 14; i++) begin
            run_cycle(tab[i], $sformatf("v%0d", i));
        end

        // Accept a write, then reset before it and a second acceptance issue
        wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 4'hD; ld_valid = 1'b0;
        #1;
        chk("mid wb_ready", 8'(wb_ready), 8'h01);
        @(posedge clk); #1;
        chk("mid rf_we", 8'(rf_we), 8'h01);
        chk("mid rf_wdata", 8'(rf_wdata), 8'h0D);
        wb_valid = 1'b0; ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 4'h5;
        #1;
        chk("mid ld_ready", 8'(ld_ready), 8'h01);
        #1;
        rst_n = 1'b0; ld_valid = 1'b0;
        #1;
        chk("async rf_we", 8'(rf_we), 8'h00);
        chk("async rf_waddr", 8'(rf_waddr), 8'h00);
        chk("async rf_wdata", 8'(rf_wdata), 8'h00);
        sb_q.delete();
        mdl_a = 2'd0; mdl_d = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        init_walk(1'b0, "init2");
        for (int i = 0; i < 4; i++) begin
            run_cycle(post[i], $sformatf("p%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
